// File: rtl/parser_pkg.sv
// Shared types and constants for the parametrised packet parser.
//   parser_state_t : parser FSM states (ETH header, IP header, TCP header, payload)
//   DEF_*_WORDS    : default header lengths in stream words
//   hdr_bits()     : width in bits of a header made of `words` words of `width` bits
package parser_pkg;

  typedef enum logic [1:0] {
    S_ETH,
    S_IP,
    S_TCP,
    S_PAYLOAD
  } parser_state_t;

  localparam int DEF_ETH_WORDS = 4;
  localparam int DEF_IP_WORDS  = 5;
  localparam int DEF_TCP_WORDS = 5;

  function automatic int hdr_bits(input int words, input int width);
    return words * width;
  endfunction

endpackage

// File: rtl/parser_out_reg.sv
// Single-entry valid/ready payload register carrying a last bit.
//   clk, rst        : clock, asynchronous active-low reset
//   load            : accept data/last this cycle (only asserted when space is high)
//   data, last      : incoming payload word and its end-of-packet flag
//   space           : register can take a word this cycle (empty, or draining now)
//   data_out, valid_out, last_out, ready_out : downstream valid/ready stream
module parser_out_reg
  import parser_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             last,
  output logic             space,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             last_out,
  input  logic             ready_out
);

  // A word may be loaded while the held word drains in the same cycle,
  // which keeps a continuously ready sink at one word per cycle.
  assign space = !valid_out || ready_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
    end else if (load) begin
      data_out  <= data;
      last_out  <= last;
      valid_out <= 1'b1;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/param_packet_parser.sv
// Parametrised Ethernet/IP/TCP stream parser.
// Consumes a WIDTH-bit word stream (first word of each header ends up in the
// MSBs), commits the three headers to stable parallel registers once the last
// TCP word arrives, and forwards the payload through a single-entry register.
//
// Handshake: a word moves on any rising edge where its valid and ready are
// both high; valid never depends on ready, and a raised valid with its data
// is held unchanged until the transfer happens.
//
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   data_in, valid_in, last_in    : upstream word stream (last_in marks packet end)
//   ready_in                      : parser accepts data_in this cycle
//   data_out, valid_out, last_out : payload stream to the DMA-side FIFO
//   ready_out                     : downstream ready
//   eth_hdr, ip_hdr, tcp_hdr      : committed headers
//   hdr_valid                     : one-cycle pulse after a header commit
//   err_runt                      : one-cycle pulse after a packet ended inside its headers
//   pkt_cnt, runt_cnt             : good / runt packet counters (wrap)
//   state                         : current FSM state, for observation
//
// Build option: define PARSER_STATS_EN to enable pkt_cnt/runt_cnt; otherwise
// both counters are tied to zero.
module param_packet_parser
  import parser_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ETH_WORDS = DEF_ETH_WORDS,
  parameter int IP_WORDS  = DEF_IP_WORDS,
  parameter int TCP_WORDS = DEF_TCP_WORDS,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               data_in,
  input  logic                           valid_in,
  input  logic                           last_in,
  output logic                           ready_in,
  output logic [WIDTH-1:0]               data_out,
  output logic                           valid_out,
  output logic                           last_out,
  input  logic                           ready_out,
  output logic [ETH_WORDS*WIDTH-1:0]     eth_hdr,
  output logic [IP_WORDS*WIDTH-1:0]      ip_hdr,
  output logic [TCP_WORDS*WIDTH-1:0]     tcp_hdr,
  output logic                           hdr_valid,
  output logic                           err_runt,
  output logic [CNT_W-1:0]               pkt_cnt,
  output logic [CNT_W-1:0]               runt_cnt,
  output parser_state_t                  state
);

  localparam int ETH_BITS  = hdr_bits(ETH_WORDS, WIDTH);
  localparam int IP_BITS   = hdr_bits(IP_WORDS, WIDTH);
  localparam int TCP_BITS  = hdr_bits(TCP_WORDS, WIDTH);
  localparam int MAX_WORDS = (ETH_WORDS > IP_WORDS) ?
                             ((ETH_WORDS > TCP_WORDS) ? ETH_WORDS : TCP_WORDS) :
                             ((IP_WORDS > TCP_WORDS) ? IP_WORDS : TCP_WORDS);
  localparam int CW        = $clog2(MAX_WORDS + 1);

  parser_state_t  state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [ETH_BITS-1:0] eth_stage, eth_shift;
  logic [IP_BITS-1:0]  ip_stage, ip_shift;
  logic [TCP_BITS-1:0] tcp_stage, tcp_shift;

  logic shift_eth, shift_ip, shift_tcp;
  logic commit, runt, load, space;

  // Left shift with the new word entering the LSBs; the cast drops the
  // oldest word once the register is full.
  assign eth_shift = ETH_BITS'({eth_stage, data_in});
  assign ip_shift  = IP_BITS'({ip_stage, data_in});
  assign tcp_shift = TCP_BITS'({tcp_stage, data_in});

  assign state = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_in  = 1'b0;
    shift_eth = 1'b0;
    shift_ip  = 1'b0;
    shift_tcp = 1'b0;
    commit    = 1'b0;
    runt      = 1'b0;
    load      = 1'b0;
    case (state_q)
      S_ETH: begin
        ready_in = 1'b1;
        if (valid_in) begin
          shift_eth = 1'b1;
          if (last_in) begin
            runt  = 1'b1;
            cnt_d = '0;
          end else if (cnt_q == CW'(ETH_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = S_IP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_IP: begin
        ready_in = 1'b1;
        if (valid_in) begin
          shift_ip = 1'b1;
          if (last_in) begin
            runt    = 1'b1;
            cnt_d   = '0;
            state_d = S_ETH;
          end else if (cnt_q == CW'(IP_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = S_TCP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_TCP: begin
        ready_in = 1'b1;
        if (valid_in) begin
          shift_tcp = 1'b1;
          if (cnt_q == CW'(TCP_WORDS - 1)) begin
            // Final header word: commit; last here means a zero-payload packet.
            commit  = 1'b1;
            cnt_d   = '0;
            state_d = last_in ? S_ETH : S_PAYLOAD;
          end else if (last_in) begin
            runt    = 1'b1;
            cnt_d   = '0;
            state_d = S_ETH;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_PAYLOAD: begin
        ready_in = space;
        if (valid_in && space) begin
          load = 1'b1;
          if (last_in) begin
            state_d = S_ETH;
          end
        end
      end
      default: begin
        state_d = S_ETH;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_ETH;
      cnt_q     <= '0;
      eth_stage <= '0;
      ip_stage  <= '0;
      tcp_stage <= '0;
      eth_hdr   <= '0;
      ip_hdr    <= '0;
      tcp_hdr   <= '0;
      hdr_valid <= 1'b0;
      err_runt  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_valid <= commit;
      err_runt  <= runt;
      if (shift_eth) eth_stage <= eth_shift;
      if (shift_ip)  ip_stage  <= ip_shift;
      if (shift_tcp) tcp_stage <= tcp_shift;
      // The final TCP word is still on data_in, so take the shifted value.
      if (commit) begin
        eth_hdr <= eth_stage;
        ip_hdr  <= ip_stage;
        tcp_hdr <= tcp_shift;
      end
    end
  end

  parser_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data      (data_in),
    .last      (last_in),
    .space     (space),
    .data_out  (data_out),
    .valid_out (valid_out),
    .last_out  (last_out),
    .ready_out (ready_out)
  );

`ifdef PARSER_STATS_EN
  logic [CNT_W-1:0] pkt_q, runt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_q  <= '0;
      runt_q <= '0;
    end else begin
      if (commit) pkt_q  <= pkt_q + CNT_W'(1);
      if (runt)   runt_q <= runt_q + CNT_W'(1);
    end
  end

  assign pkt_cnt  = pkt_q;
  assign runt_cnt = runt_q;
`else
  assign pkt_cnt  = '0;
  assign runt_cnt = '0;
`endif

endmodule

// File: tb/tb_param_packet_parser.sv
// Bench for param_packet_parser: a 32-bit default instance (a_*) and a
// 64-bit instance with 2/3/3-word headers (b_*). Payload words are pushed
// to per-instance expected queues when driven and popped by a monitor.
module tb_param_packet_parser;
  import parser_pkg::*;

`ifdef PARSER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic [31:0]   a_data_in, a_data_out;
  logic          a_valid_in, a_last_in, a_ready_in;
  logic          a_valid_out, a_last_out, a_ready_out;
  logic [127:0]  a_eth;
  logic [159:0]  a_ip, a_tcp;
  logic          a_hdr_valid, a_err_runt;
  logic [15:0]   a_pkt_cnt, a_runt_cnt;
  parser_state_t a_state;

  // 64-bit instance
  logic [63:0]   b_data_in, b_data_out;
  logic          b_valid_in, b_last_in, b_ready_in;
  logic          b_valid_out, b_last_out, b_ready_out;
  logic [127:0]  b_eth;
  logic [191:0]  b_ip, b_tcp;
  logic          b_hdr_valid, b_err_runt;
  logic [15:0]   b_pkt_cnt, b_runt_cnt;
  parser_state_t b_state;

  param_packet_parser u_dut_a (
    .clk(clk), .rst(rst),
    .data_in(a_data_in), .valid_in(a_valid_in), .last_in(a_last_in), .ready_in(a_ready_in),
    .data_out(a_data_out), .valid_out(a_valid_out), .last_out(a_last_out), .ready_out(a_ready_out),
    .eth_hdr(a_eth), .ip_hdr(a_ip), .tcp_hdr(a_tcp),
    .hdr_valid(a_hdr_valid), .err_runt(a_err_runt),
    .pkt_cnt(a_pkt_cnt), .runt_cnt(a_runt_cnt), .state(a_state)
  );

  param_packet_parser #(.WIDTH(64), .ETH_WORDS(2), .IP_WORDS(3), .TCP_WORDS(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .data_in(b_data_in), .valid_in(b_valid_in), .last_in(b_last_in), .ready_in(b_ready_in),
    .data_out(b_data_out), .valid_out(b_valid_out), .last_out(b_last_out), .ready_out(b_ready_out),
    .eth_hdr(b_eth), .ip_hdr(b_ip), .tcp_hdr(b_tcp),
    .hdr_valid(b_hdr_valid), .err_runt(b_err_runt),
    .pkt_cnt(b_pkt_cnt), .runt_cnt(b_runt_cnt), .state(b_state)
  );

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [32:0] a_exp_q[$];
  logic [64:0] b_exp_q[$];
  int a_hv = 0, a_er = 0, a_outs = 0;
  int b_hv = 0, b_outs = 0;
  logic        a_hold = 1'b0;
  logic [32:0] a_hold_val = '0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  // monitor: sampled 2 time units after the falling edge, so any transfer
  // seen here happens on the next rising edge
  always @(negedge clk) begin
    #2;
    if (a_hdr_valid) a_hv++;
    if (a_err_runt)  a_er++;
    if (b_hdr_valid) b_hv++;
    if (a_valid_out && a_ready_out) begin
      a_outs++;
      check("a_q_nonempty", a_exp_q.size() != 0, 1'b1);
      if (a_exp_q.size() != 0) check("a_payload", {a_last_out, a_data_out}, a_exp_q.pop_front());
    end
    if (a_valid_out && !a_ready_out) begin
      if (a_hold) check("a_hold_stable", {a_last_out, a_data_out}, a_hold_val);
      a_hold     = 1'b1;
      a_hold_val = {a_last_out, a_data_out};
    end else begin
      a_hold = 1'b0;
    end
    if (b_valid_out && b_ready_out) begin
      b_outs++;
      check("b_q_nonempty", b_exp_q.size() != 0, 1'b1);
      if (b_exp_q.size() != 0) check("b_payload", {b_last_out, b_data_out}, b_exp_q.pop_front());
    end
  end

  // driver tasks: called at a falling edge, return at the falling edge
  // after the word was accepted
  task automatic drive_a(input logic [31:0] d, input logic l);
    int guard = 0;
    a_data_in = d; a_last_in = l; a_valid_in = 1'b1;
    #1;
    while (!a_ready_in && guard < 100) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 100) check("a_ready_timeout", a_ready_in, 1'b1);
    @(negedge clk);
    a_valid_in = 1'b0; a_last_in = 1'b0;
  endtask

  task automatic drive_b(input logic [63:0] d, input logic l);
    int guard = 0;
    b_data_in = d; b_last_in = l; b_valid_in = 1'b1;
    #1;
    while (!b_ready_in && guard < 100) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 100) check("b_ready_timeout", b_ready_in, 1'b1);
    @(negedge clk);
    b_valid_in = 1'b0; b_last_in = 1'b0;
  endtask

  task automatic pay_a(input logic [31:0] w, input logic l);
    a_exp_q.push_back({l, w});
    drive_a(w, l);
  endtask

  // 14 random header words; returns them concatenated, first word in MSBs
  task automatic send_hdrs_a(output logic [447:0] hdr);
    logic [31:0] w;
    hdr = '0;
    for (int i = 0; i < 14; i++) begin
      w   = $urandom;
      hdr = {hdr[415:0], w};
      drive_a(w, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [127:0] t1_eth;
  logic [159:0] t1_ip, t1_tcp;
  logic [447:0] hdr;
  logic [63:0]  bw[12];
  logic [31:0]  w;
  int hv0, er0, outs0;

  initial begin
    t1_eth = 128'h8F3A9C127BD4E6A055CC11AA44907F3E;
    t1_ip  = {5{32'h00112233}};
    t1_tcp = {5{32'hFFEEDDCC}};
    rst = 1'b0;
    a_data_in = '0; a_valid_in = 1'b0; a_last_in = 1'b0; a_ready_out = 1'b1;
    b_data_in = '0; b_valid_in = 1'b0; b_last_in = 1'b0; b_ready_out = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid_out", a_valid_out, 1'b0);
    check("rst_hdr_valid", a_hdr_valid, 1'b0);
    check("rst_err_runt", a_err_runt, 1'b0);
    check("rst_eth", a_eth, '0);
    check("rst_pkt_cnt", a_pkt_cnt, '0);
    check("rst_state", a_state, S_ETH);
    check("rst_ready_in", a_ready_in, 1'b1);
    check("rst_b_valid_out", b_valid_out, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // packet 1: fixed headers, ten payload words
    hv0 = a_hv; outs0 = a_outs;
    for (int i = 0; i < 24; i++) begin
      if (i < 4)        w = t1_eth[127 - 32*i -: 32];
      else if (i < 9)   w = 32'h00112233;
      else if (i < 14)  w = 32'hFFEEDDCC;
      else if (i[0] == 1'b0) w = 32'h01234567;
      else              w = 32'h89ABCDEF;
      if (i >= 14) pay_a(w, i == 23);
      else         drive_a(w, 1'b0);
      if (i == 13) begin
        #1;
        check("t1_hdr_valid_pulse", a_hdr_valid, 1'b1);
        check("t1_eth_at_commit", a_eth, t1_eth);
      end
      if (i == 14) begin
        #1;
        check("t1_hdr_valid_low", a_hdr_valid, 1'b0);
      end
    end
    repeat (3) @(negedge clk);
    check("t1_eth", a_eth, t1_eth);
    check("t1_ip", a_ip, t1_ip);
    check("t1_tcp", a_tcp, t1_tcp);
    check("t1_hv_count", a_hv - hv0, 1);
    check("t1_out_count", a_outs - outs0, 10);
    check("t1_q_empty", a_exp_q.size(), 0);
    check("t1_pkt_cnt", a_pkt_cnt, cnt_exp(1));

    // runt: six words, ends inside the IP header
    hv0 = a_hv; er0 = a_er; outs0 = a_outs;
    for (int i = 0; i < 6; i++) drive_a(32'hA1A1A1A1, i == 5);
    #1;
    check("runt_pulse", a_err_runt, 1'b1);
    repeat (3) @(negedge clk);
    check("runt_count", a_er - er0, 1);
    check("runt_no_hv", a_hv - hv0, 0);
    check("runt_no_out", a_outs - outs0, 0);
    check("runt_eth_kept", a_eth, t1_eth);
    check("runt_ip_kept", a_ip, t1_ip);
    check("runt_tcp_kept", a_tcp, t1_tcp);
    check("runt_state", a_state, S_ETH);
    check("runt_runt_cnt", a_runt_cnt, cnt_exp(1));

    // zero-payload packet
    hv0 = a_hv; outs0 = a_outs;
    for (int i = 0; i < 14; i++) drive_a(32'hC3C3C3C3, i == 13);
    #1;
    check("zp_hdr_valid", a_hdr_valid, 1'b1);
    repeat (3) @(negedge clk);
    check("zp_eth", a_eth, {4{32'hC3C3C3C3}});
    check("zp_tcp", a_tcp, {5{32'hC3C3C3C3}});
    check("zp_no_out", a_outs - outs0, 0);
    check("zp_hv_count", a_hv - hv0, 1);
    check("zp_state", a_state, S_ETH);
    check("zp_pkt_cnt", a_pkt_cnt, cnt_exp(2));

    // backpressure: stall the sink for five cycles mid-payload
    outs0 = a_outs;
    send_hdrs_a(hdr);
    for (int i = 0; i < 3; i++) pay_a(32'hD4F40099 + 32'(i), 1'b0);
    a_ready_out = 1'b0;
    a_exp_q.push_back({1'b0, 32'hD4F40099 + 32'd3});
    a_data_in = 32'hD4F40099 + 32'd3; a_last_in = 1'b0; a_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready_in_low", a_ready_in, 1'b0);
      check("bp_data_held", {a_valid_out, a_data_out}, {1'b1, 32'hD4F40099 + 32'd2});
      @(negedge clk);
    end
    a_ready_out = 1'b1;
    #1;
    check("bp_ready_in_release", a_ready_in, 1'b1);
    @(negedge clk);
    a_valid_in = 1'b0;
    for (int i = 4; i < 6; i++) pay_a(32'hD4F40099 + 32'(i), i == 5);
    repeat (3) @(negedge clk);
    check("bp_eth", a_eth, hdr[447:320]);
    check("bp_ip", a_ip, hdr[319:160]);
    check("bp_tcp", a_tcp, hdr[159:0]);
    check("bp_out_count", a_outs - outs0, 6);
    check("bp_q_empty", a_exp_q.size(), 0);
    check("bp_pkt_cnt", a_pkt_cnt, cnt_exp(3));

    // reset mid-payload with a word held, then a fresh packet
    send_hdrs_a(hdr);
    pay_a(32'h5A5A0001, 1'b0);
    pay_a(32'h5A5A0002, 1'b0);
    a_ready_out = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("mr_valid_out", a_valid_out, 1'b0);
    check("mr_data_out", a_data_out, '0);
    check("mr_eth", a_eth, '0);
    check("mr_ip", a_ip, '0);
    check("mr_tcp", a_tcp, '0);
    check("mr_pkt_cnt", a_pkt_cnt, '0);
    check("mr_state", a_state, S_ETH);
    a_exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    a_ready_out = 1'b1;
    outs0 = a_outs;
    send_hdrs_a(hdr);
    for (int i = 0; i < 3; i++) pay_a($urandom, i == 2);
    repeat (3) @(negedge clk);
    check("mr_fresh_eth", a_eth, hdr[447:320]);
    check("mr_fresh_ip", a_ip, hdr[319:160]);
    check("mr_fresh_tcp", a_tcp, hdr[159:0]);
    check("mr_fresh_outs", a_outs - outs0, 3);
    check("mr_fresh_q_empty", a_exp_q.size(), 0);
    check("mr_fresh_pkt_cnt", a_pkt_cnt, cnt_exp(1));
    check("mr_fresh_runt_cnt", a_runt_cnt, cnt_exp(0));

    // 64-bit instance: 2/3/3 header words, four payload words
    hv0 = b_hv; outs0 = b_outs;
    for (int i = 0; i < 12; i++) begin
      bw[i] = {$urandom, $urandom};
      if (i >= 8) b_exp_q.push_back({i == 11, bw[i]});
      drive_b(bw[i], i == 11);
    end
    repeat (3) @(negedge clk);
    check("w64_eth", b_eth, {bw[0], bw[1]});
    check("w64_ip", b_ip, {bw[2], bw[3], bw[4]});
    check("w64_tcp", b_tcp, {bw[5], bw[6], bw[7]});
    check("w64_hv_count", b_hv - hv0, 1);
    check("w64_out_count", b_outs - outs0, 4);
    check("w64_q_empty", b_exp_q.size(), 0);
    check("w64_pkt_cnt", b_pkt_cnt, cnt_exp(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
